// File: rtl/sw_conditioner.sv
// sw_conditioner: synchronize and debounce switches, emit edge pulses and queue per-switch change events
module sw_conditioner #(
   parameter int NSW        = 10,
   parameter int DB_CYCLES  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NSW-1:0] sw_raw,
   output logic [NSW-1:0] sw_level,
   output logic [NSW-1:0] sw_rise,
   output logic [NSW-1:0] sw_fall,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [3:0]     evt_idx,
   output logic           evt_level,
   output logic           evt_collapse
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [NSW-1:0] s1_q, s2_q, lvl_q, lvl_d, rise_q, fall_q, pend_q, pend_d, flip, push_mask;
   logic [CW-1:0]  cnt_q [NSW];
   logic [CW-1:0]  cnt_d [NSW];
   logic [4:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]  wr_q, rd_q;
   logic [PW:0]    count_q;
   logic           collapse_q, collapse, push, pop;
   logic [3:0]     push_idx;
   always_comb begin
      for (int i = 0; i < NSW; i++) begin
         lvl_d[i] = (s2_q[i] != lvl_q[i] && cnt_q[i] == CW'(DB_CYCLES - 1)) ? s2_q[i] : lvl_q[i];
         cnt_d[i] = (s2_q[i] == lvl_q[i] || cnt_q[i] == CW'(DB_CYCLES - 1)) ? '0 : cnt_q[i] + 1'b1;
      end
   end
   always_comb begin
      push_idx = '0;
      for (int i = NSW - 1; i >= 0; i--) push_idx = pend_q[i] ? 4'(i) : push_idx;
   end
   assign push      = |pend_q && count_q != (PW+1)'(FIFO_DEPTH);
   assign pop       = evt_valid && evt_ready;
   assign push_mask = push ? NSW'(1) << push_idx : '0;
   assign flip      = lvl_d ^ lvl_q;
   assign pend_d    = (pend_q & ~push_mask) | flip;
   assign collapse  = |(flip & pend_q & ~push_mask);
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         lvl_q      <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
         pend_q     <= '0;
         cnt_q      <= '{default: '0};
         mem_q      <= '{default: '0};
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         collapse_q <= 1'b0;
      end else begin
         s1_q       <= sw_raw;
         s2_q       <= s1_q;
         lvl_q      <= lvl_d;
         cnt_q      <= cnt_d;
         rise_q     <= lvl_d & ~lvl_q;
         fall_q     <= ~lvl_d & lvl_q;
         pend_q     <= pend_d;
         collapse_q <= collapse_q | collapse;
         if (push) begin
            mem_q[wr_q] <= {push_idx, lvl_q[push_idx]};
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   assign sw_level             = lvl_q;
   assign sw_rise              = rise_q;
   assign sw_fall              = fall_q;
   assign evt_valid            = count_q != '0;
   assign {evt_idx, evt_level} = mem_q[rd_q];
   assign evt_collapse         = collapse_q;
endmodule

// File: tb/tb_sw_conditioner.sv
// tb_sw_conditioner: directed scenarios plus random stimulus against a queue-based reference model
module tb_sw_conditioner;
   localparam int NSW   = 10;
   localparam int DB    = 4;
   localparam int DEPTH = 4;

   logic           clk, rst, evt_ready, evt_valid, evt_level, evt_collapse;
   logic [NSW-1:0] sw_raw, sw_level, sw_rise, sw_fall;
   logic [3:0]     evt_idx;
   int             checks, failures;

   sw_conditioner #(.NSW(NSW), .DB_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_level(sw_level), .sw_rise(sw_rise),
      .sw_fall(sw_fall), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
      .evt_level(evt_level), .evt_collapse(evt_collapse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a switch adopts its synchronized value after DB consecutive disagreeing samples
   logic [NSW-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_pend, m_nl, m_pmask;
   bit             m_coll, m_pop;
   int             m_run [NSW];
   int             m_pi;
   int             q_idx [$];
   bit             q_lvl [$];

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_coll = 0;
         foreach (m_run[i]) m_run[i] = 0;
         q_idx.delete(); q_lvl.delete();
      end else begin
         m_pop = q_idx.size() != 0 && evt_ready;
         m_pi = -1;
         m_pmask = '0;
         if (q_idx.size() < DEPTH)
            for (int i = 0; i < NSW; i++) if (m_pend[i]) begin m_pi = i; break; end
         if (m_pi >= 0) m_pmask[m_pi] = 1'b1;
         m_nl = m_lvl;
         for (int i = 0; i < NSW; i++) begin
            m_run[i] = (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DB) begin m_nl[i] = m_s2[i]; m_run[i] = 0; end
         end
         m_rise = m_nl & ~m_lvl;
         m_fall = ~m_nl & m_lvl;
         if (((m_nl ^ m_lvl) & m_pend & ~m_pmask) != 0) m_coll = 1;
         m_pend = (m_pend & ~m_pmask) | (m_nl ^ m_lvl);
         if (m_pop) begin void'(q_idx.pop_front()); void'(q_lvl.pop_front()); end
         if (m_pi >= 0) begin q_idx.push_back(m_pi); q_lvl.push_back(m_lvl[m_pi]); end
         m_s2 = m_s1; m_s1 = sw_raw; m_lvl = m_nl;
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sw_raw = '0; evt_ready = 1'b0;
      tick(3);
      checks++;
      if (sw_level !== '0 || sw_rise !== '0 || sw_fall !== '0 || evt_valid !== 1'b0 ||
          evt_idx !== 4'd0 || evt_level !== 1'b0 || evt_collapse !== 1'b0) begin
         failures++;
         $display("FAIL reset: level=%h rise=%h fall=%h valid=%b idx=%0d lvl=%b coll=%b, all must be 0",
                  sw_level, sw_rise, sw_fall, evt_valid, evt_idx, evt_level, evt_collapse);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      sw_raw = 10'h001;
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         if (e == 5) begin
            checks++;
            if (sw_level !== 10'h000) begin failures++; $display("FAIL single_early: level=%h expected 000", sw_level); end
         end
         if (e == 6) begin
            checks++;
            if (sw_level !== 10'h001 || sw_rise !== 10'h001 || evt_valid !== 1'b0) begin
               failures++; $display("FAIL single_rise: level=%h rise=%h valid=%b expected 001 001 0", sw_level, sw_rise, evt_valid);
            end
         end
         if (e == 7) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_idx !== 4'd0 || evt_level !== 1'b1 || sw_rise !== 10'h000) begin
               failures++; $display("FAIL single_event: valid=%b idx=%0d lvl=%b rise=%h expected 1 0 1 000", evt_valid, evt_idx, evt_level, sw_rise);
            end
         end
      end
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_pop: valid=%b expected 0", evt_valid); end
   endtask

   task automatic test_glitch();
      int bad, rise_at, fall_at;
      bad = 0; rise_at = -1; fall_at = -1;
      sw_raw[3] = 1'b1;
      tick(3);
      sw_raw[3] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         if (sw_level !== 10'h001 || sw_rise !== '0 || sw_fall !== '0 || evt_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL glitch_filtered: bad_cycles=%0d expected 0", bad); end
      sw_raw[3] = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick(1);
         if (c == 4) sw_raw[3] = 1'b0;
         if (sw_rise[3] === 1'b1) rise_at = c;
         if (sw_fall[3] === 1'b1) fall_at = c;
      end
      checks++;
      if (rise_at != 6 || fall_at != 10) begin
         failures++; $display("FAIL glitch_pulse: rise_at=%0d fall_at=%0d expected 6 10", rise_at, fall_at);
      end
      checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 4'd3 || evt_level !== 1'b1) begin
         failures++; $display("FAIL glitch_evt_rise: valid=%b idx=%0d lvl=%b expected 1 3 1", evt_valid, evt_idx, evt_level);
      end
      evt_ready = 1'b1;
      tick(1);
      checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 4'd3 || evt_level !== 1'b0) begin
         failures++; $display("FAIL glitch_evt_fall: valid=%b idx=%0d lvl=%b expected 1 3 0", evt_valid, evt_idx, evt_level);
      end
      tick(1);
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin failures++; $display("FAIL glitch_drain: valid=%b expected 0", evt_valid); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      sw_raw = 10'h3FF; evt_ready = 1'b0;
      tick(6);
      checks++;
      if (sw_rise !== 10'h3FF || sw_level !== 10'h3FF) begin
         failures++; $display("FAIL simul_rise: rise=%h level=%h expected 3ff 3ff", sw_rise, sw_level);
      end
      tick(6);
      checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 4'd0 || evt_level !== 1'b1) begin
         failures++; $display("FAIL full_hold: valid=%b idx=%0d lvl=%b expected 1 0 1", evt_valid, evt_idx, evt_level);
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_idx !== 4'(k) || evt_level !== 1'b1) begin
            failures++; $display("FAIL simul_order: slot=%0d valid=%b idx=%0d lvl=%b expected 1 %0d 1", k, evt_valid, evt_idx, evt_level, k);
         end
         tick(1);
      end
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin failures++; $display("FAIL simul_drain: valid=%b expected 0", evt_valid); end
   endtask

   task automatic test_collapse();
      int exp_idx [5] = '{0, 1, 2, 3, 5};
      bit exp_lvl [5] = '{1, 1, 1, 1, 0};
      do_reset();
      sw_raw = 10'h02F; evt_ready = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         tick(1);
         if (c == 8) sw_raw = 10'h00F;
         if (c == 13) begin
            checks++;
            if (evt_collapse !== 1'b0) begin failures++; $display("FAIL collapse_early: coll=%b expected 0", evt_collapse); end
         end
      end
      checks++;
      if (evt_collapse !== 1'b1) begin failures++; $display("FAIL collapse_set: coll=%b expected 1", evt_collapse); end
      evt_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_idx !== 4'(exp_idx[k]) || evt_level !== exp_lvl[k]) begin
            failures++; $display("FAIL collapse_order: slot=%0d valid=%b idx=%0d lvl=%b expected 1 %0d %0d",
                                 k, evt_valid, evt_idx, evt_level, exp_idx[k], exp_lvl[k]);
         end
         tick(1);
      end
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0 || evt_collapse !== 1'b1) begin
         failures++; $display("FAIL collapse_sticky: valid=%b coll=%b expected 0 1", evt_valid, evt_collapse);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 5) == 0) sw_raw = sw_raw ^ NSW'(1 << $urandom_range(0, NSW - 1));
         else if ($urandom_range(0, 60) == 0) sw_raw = NSW'($urandom);
         evt_ready = ($urandom_range(0, 2) == 0);
         tick(1);
         checks++;
         if (sw_level !== m_lvl || sw_rise !== m_rise || sw_fall !== m_fall) begin
            failures++; $display("FAIL rand_level: cyc=%0d level=%h rise=%h fall=%h expected %h %h %h",
                                 n, sw_level, sw_rise, sw_fall, m_lvl, m_rise, m_fall);
         end
         checks++;
         if (evt_valid !== (q_idx.size() != 0) || evt_collapse !== m_coll) begin
            failures++; $display("FAIL rand_valid: cyc=%0d valid=%b coll=%b expected %b %b",
                                 n, evt_valid, evt_collapse, q_idx.size() != 0, m_coll);
         end
         if (q_idx.size() != 0) begin
            checks++;
            if (evt_idx !== 4'(q_idx[0]) || evt_level !== q_lvl[0]) begin
               failures++; $display("FAIL rand_head: cyc=%0d idx=%0d lvl=%b expected %0d %b", n, evt_idx, evt_level, q_idx[0], q_lvl[0]);
            end
         end
      end
      evt_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      sw_raw = 10'h07F; evt_ready = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick(1);
         if (c == 8) sw_raw = 10'h03F;
      end
      checks++;
      if (evt_valid !== 1'b1 || evt_collapse !== 1'b1) begin
         failures++; $display("FAIL mid_setup: valid=%b coll=%b expected 1 1", evt_valid, evt_collapse);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if (evt_valid !== 1'b0 || sw_level !== '0 || evt_collapse !== 1'b0 || sw_fall !== '0) begin
         failures++; $display("FAIL mid_reset: valid=%b level=%h coll=%b fall=%h expected 0 000 0 000",
                              evt_valid, sw_level, evt_collapse, sw_fall);
      end
      for (int c = 1; c <= 7; c++) begin
         tick(1);
         if (c == 6) begin
            checks++;
            if (sw_rise !== 10'h03F) begin failures++; $display("FAIL mid_release_rise: rise=%h expected 03f", sw_rise); end
         end
      end
      checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 4'd0 || evt_level !== 1'b1) begin
         failures++; $display("FAIL mid_release_evt: valid=%b idx=%0d lvl=%b expected 1 0 1", evt_valid, evt_idx, evt_level);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; sw_raw = '0; evt_ready = 1'b0;
      test_reset();
      test_single();
      test_glitch();
      test_simultaneous();
      test_collapse();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
